// File: rtl/bus_demux4_if.sv
// CPU-side request/response and target-side steering signals of the 1-to-4 bus demux.
interface bus_demux4_if;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_ack;
    logic        m_err;
    logic [31:0] m_rdata;
    logic [3:0]  s_req;
    logic        s_we;
    logic [31:0] s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_be;
    logic [3:0]  s_ack;
    logic [31:0] s_rdata0;
    logic [31:0] s_rdata1;
    logic [31:0] s_rdata2;
    logic [31:0] s_rdata3;

    // demux view
    modport slave (
        input  m_req, m_we, m_addr, m_wdata, m_be,
        output m_ack, m_err, m_rdata,
        output s_req, s_we, s_addr, s_wdata, s_be,
        input  s_ack, s_rdata0, s_rdata1, s_rdata2, s_rdata3
    );

    // environment view: CPU plus the four targets
    modport master (
        output m_req, m_we, m_addr, m_wdata, m_be,
        input  m_ack, m_err, m_rdata,
        input  s_req, s_we, s_addr, s_wdata, s_be,
        output s_ack, s_rdata0, s_rdata1, s_rdata2, s_rdata3
    );
endinterface

// File: rtl/bus_demux4.sv
// Steers one CPU bus request to one of four targets and returns the selected
// target's read data, with a timeout so a silent target cannot hang the core.
module bus_demux4 #(
    parameter int SEL_LSB = 30,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input logic           clk,
    input logic           rst,
    bus_demux4_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_t          state;
    logic [1:0]      sel;
    logic [TO_W-1:0] timer;
    logic [31:0]     sel_rdata;

    always_comb begin
        sel_rdata = bus.s_rdata0;
        case (sel)
            2'd1:    sel_rdata = bus.s_rdata1;
            2'd2:    sel_rdata = bus.s_rdata2;
            2'd3:    sel_rdata = bus.s_rdata3;
            default: sel_rdata = bus.s_rdata0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sel         <= 2'd0;
            timer       <= '0;
            bus.s_req   <= 4'b0;
            bus.m_ack   <= 1'b0;
            bus.m_err   <= 1'b0;
            bus.m_rdata <= 32'd0;
            bus.s_we    <= 1'b0;
            bus.s_addr  <= 32'd0;
            bus.s_wdata <= 32'd0;
            bus.s_be    <= 4'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.m_req) begin
                        bus.s_we    <= bus.m_we;
                        bus.s_addr  <= bus.m_addr;
                        bus.s_wdata <= bus.m_wdata;
                        bus.s_be    <= bus.m_be;
                        sel         <= bus.m_addr[SEL_LSB +: 2];
                        bus.s_req   <= 4'b0001 << bus.m_addr[SEL_LSB +: 2];
                        timer       <= '0;
                        state       <= BUSY;
                    end else begin
                        bus.s_req <= 4'b0;
                    end
                end
                BUSY: begin
                    // an ack from the selected target beats a timeout in the same cycle
                    if (bus.s_ack[sel]) begin
                        bus.m_rdata <= bus.s_we ? 32'd0 : sel_rdata;
                        bus.s_req   <= 4'b0;
                        bus.m_err   <= 1'b0;
                        bus.m_ack   <= 1'b1;
                        state       <= RESP;
                    end else if (TIMEOUT != 0 && timer == TO_LAST) begin
                        bus.m_rdata <= 32'd0;
                        bus.s_req   <= 4'b0;
                        bus.m_err   <= 1'b1;
                        bus.m_ack   <= 1'b1;
                        state       <= RESP;
                    end else if (timer != '1) begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    bus.m_ack <= 1'b0;
                    bus.m_err <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
